// File: rtl/uart_tx_fifo_if.sv
// Producer write handshake plus the start/busy handshake towards the UART transmitter.
// The slave modport belongs to the FIFO; the master side is the producer and transmitter.
interface uart_tx_fifo_if;
   logic       wr_vld;
   logic [7:0] wr_dat;
   logic       wr_rdy;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_dat;

   modport master (output wr_vld, wr_dat, tx_busy,
                   input  wr_rdy, tx_start, tx_dat);
   modport slave  (input  wr_vld, wr_dat, tx_busy,
                   output wr_rdy, tx_start, tx_dat);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter; a byte written into an idle, empty queue raises tx_start one edge later.
// Backpressure: wr_rdy drops when full; writes offered while full are dropped and latched in overflow.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int TMO   = 15
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   uart_tx_fifo_if.slave          bus,
   input  logic                   ovf_clr_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic                   overflow_o,
   output logic                   start_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TMO < 1) ? 1 : $clog2(TMO + 1);

   typedef enum logic [1:0] {IDLE, START, BUSY} state_e;

   state_e        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    tx_dat_q, tx_dat_d;
   logic          ovf_q, ovf_d;
   logic          serr_q, serr_d;
   logic          push, pop, tmo;

   // Status flags come from the registered count only, so no input reaches them combinationally.
   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == CW'(DEPTH));
   assign bus.wr_rdy  = !full_o;
   assign bus.tx_dat  = tx_dat_q;
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign start_err_o = serr_q;
   assign push        = bus.wr_vld && !full_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!empty_o && !bus.tx_busy) state_d = START;
         START:   if (bus.tx_busy) state_d = BUSY;
                  else if (tmo)    state_d = IDLE;
         BUSY:    if (!bus.tx_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An abandoned start drops its byte: it was already popped when START was entered.
   always_comb begin
      bus.tx_start = (state_q == START);
      pop          = (state_q == IDLE) && !empty_o && !bus.tx_busy;
      tmo          = (state_q == START) && !bus.tx_busy && (timer_q == TW'(TMO));
      serr_d       = tmo;
      timer_d      = timer_q;
      if (pop)                     timer_d = '0;
      else if (state_q == START)   timer_d = timer_q + 1'b1;
      tx_dat_d     = pop ? mem_q[rd_ptr_q] : tx_dat_q;
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
      ovf_d = ovf_q;
      if (bus.wr_vld && full_o) ovf_d = 1'b1;
      else if (ovf_clr_i)       ovf_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         tx_dat_q <= 8'h00;
         ovf_q    <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_d;
         timer_q  <= timer_d;
         tx_dat_q <= tx_dat_d;
         ovf_q    <= ovf_d;
         serr_q   <= serr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_dat;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: written bytes go into a scoreboard queue, a monitor checks each tx_start.
// A small transmitter model answers tx_start with busy, holds busy permanently, or never answers.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int TMO   = 15;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   ovf_clr;
   logic [$clog2(DEPTH):0] count;
   logic                   empty, full, overflow, start_err;

   uart_tx_fifo_if u_if ();

   uart_tx_fifo #(.DEPTH(DEPTH), .TMO(TMO)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (u_if.slave),
      .ovf_clr_i   (ovf_clr),
      .count_o     (count),
      .empty_o     (empty),
      .full_o      (full),
      .overflow_o  (overflow),
      .start_err_o (start_err)
   );

   always #5 clk = ~clk;

   int         checks  = 0;
   int         errors  = 0;
   int         nstarts = 0;
   int         tx_mode = 0;   // 0: answers after 2 cycles, 1: busy held, 2: never busy
   logic [7:0] exp_q [$];
   logic       prev_start = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: every new start must carry the oldest outstanding byte and never begin while busy.
   always @(negedge clk) begin
      if (rst_n && u_if.tx_start && !prev_start) begin
         nstarts++;
         chk("start_while_busy", 32'(u_if.tx_busy), 32'd0);
         chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("tx_dat_order", 32'(u_if.tx_dat), 32'(exp_q.pop_front()));
      end
      prev_start = u_if.tx_start;
   end

   // Transmitter model, driven just after each rising edge.
   initial begin
      int hold = 0;
      int wcnt = 0;
      u_if.tx_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (tx_mode)
            1: begin u_if.tx_busy = 1'b1; hold = 0; wcnt = 0; end
            2: begin u_if.tx_busy = 1'b0; wcnt = 0; end
            default: begin
               if (u_if.tx_busy) begin
                  if (hold > 1) hold--;
                  else u_if.tx_busy = 1'b0;
               end else if (u_if.tx_start) begin
                  wcnt++;
                  if (wcnt == 2) begin u_if.tx_busy = 1'b1; hold = 3; wcnt = 0; end
               end else wcnt = 0;
            end
         endcase
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [7:0] d, input logic acc);
      u_if.wr_vld = 1'b1;
      u_if.wr_dat = d;
      @(negedge clk);
      chk("wr_rdy", 32'(u_if.wr_rdy), 32'(acc));
      if (acc) exp_q.push_back(d);
      @(posedge clk); #1;
      u_if.wr_vld = 1'b0;
   endtask

   task automatic wait_quiet(input int limit);
      int n;
      n = 0;
      while (n < limit && !(exp_q.size() == 0 && !u_if.tx_start && !u_if.tx_busy && empty)) begin
         cyc(1);
         n++;
      end
      chk("drain_done", 32'(n < limit), 32'd1);
      cyc(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int n0;
      logic [7:0] b;
      rst_n = 1'b0; ovf_clr = 1'b0; u_if.wr_vld = 1'b0; u_if.wr_dat = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_wr_rdy", 32'(u_if.wr_rdy), 32'd1);
      chk("rst_tx_start", 32'(u_if.tx_start), 32'd0);
      chk("rst_tx_dat", 32'(u_if.tx_dat), 32'h00);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_start_err", 32'(start_err), 32'd0);
      rst_n = 1'b1;
      cyc(5);
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_tx_start", 32'(u_if.tx_start), 32'd0);

      // Single byte: start one edge after the write, drops on the edge busy is seen.
      wr(8'hAF, 1'b1);
      @(negedge clk);
      chk("single_count_after_wr", 32'(count), 32'd1);
      chk("single_no_start_yet", 32'(u_if.tx_start), 32'd0);
      @(negedge clk);
      chk("single_start", 32'(u_if.tx_start), 32'd1);
      chk("single_tx_dat", 32'(u_if.tx_dat), 32'hAF);
      chk("single_count_pop", 32'(count), 32'd0);
      @(negedge clk);
      chk("single_start_held", 32'(u_if.tx_start), 32'd1);
      @(negedge clk);
      chk("single_start_drop", 32'(u_if.tx_start), 32'd0);
      chk("single_dat_stable", 32'(u_if.tx_dat), 32'hAF);
      @(posedge clk); #1;
      wait_quiet(100);

      // Back-to-back burst: first pop overlaps the second write, so count peaks at 2.
      n0 = nstarts;
      wr(8'hAF, 1'b1); chk("burst_count1", 32'(count), 32'd1);
      wr(8'h3C, 1'b1); chk("burst_count2", 32'(count), 32'd1);
      wr(8'h55, 1'b1); chk("burst_count3", 32'(count), 32'd2);
      wait_quiet(300);
      chk("burst_starts", 32'(nstarts - n0), 32'd3);

      // Fill with the transmitter busy, then overflow and clear behaviour.
      tx_mode = 1;
      cyc(2);
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'h40 + 8'(i);
         wr(b, 1'b1);
      end
      wr(8'hFF, 1'b0);
      chk("fill_count", 32'(count), 32'd16);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_wr_rdy", 32'(u_if.wr_rdy), 32'd0);
      chk("fill_overflow", 32'(overflow), 32'd1);
      ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      ovf_clr = 1'b1; wr(8'hEE, 1'b0); ovf_clr = 1'b0;
      chk("ovf_set_wins", 32'(overflow), 32'd1);
      chk("ovf_count_kept", 32'(count), 32'd16);
      ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
      chk("ovf_cleared2", 32'(overflow), 32'd0);
      tx_mode = 0;
      wait_quiet(3000);

      // Transmitter never answers: start abandoned after TMO+1 cycles.
      tx_mode = 2;
      cyc(2);
      wr(8'h12, 1'b1);
      chk("tmo_count_pre", 32'(count), 32'd1);
      cyc(1);
      chk("tmo_start", 32'(u_if.tx_start), 32'd1);
      chk("tmo_count_pop", 32'(count), 32'd0);
      n = 0;
      while (n < 40 && !start_err) begin cyc(1); n++; end
      chk("tmo_delay", 32'(n), 32'(TMO + 1));
      chk("tmo_start_low", 32'(u_if.tx_start), 32'd0);
      chk("tmo_count", 32'(count), 32'd0);
      chk("tmo_empty", 32'(empty), 32'd1);
      cyc(1);
      chk("tmo_err_pulse", 32'(start_err), 32'd0);
      chk("tmo_stays_idle", 32'(u_if.tx_start), 32'd0);

      // Reset while the transmitter is busy flushes the queue.
      tx_mode = 0;
      cyc(2);
      wr(8'hC1, 1'b1); wr(8'hC2, 1'b1); wr(8'hC3, 1'b1); wr(8'hC4, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!(u_if.tx_busy && !u_if.tx_start) && n < 50);
      chk("mid_busy_seen", 32'(n < 50), 32'd1);
      chk("mid_count", 32'(count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_start", 32'(u_if.tx_start), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_full", 32'(full), 32'd0);
      chk("mid_rst_wr_rdy", 32'(u_if.wr_rdy), 32'd1);
      chk("mid_rst_tx_dat", 32'(u_if.tx_dat), 32'h00);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      chk("mid_rst_start_err", 32'(start_err), 32'd0);
      exp_q.delete();
      cyc(3);
      rst_n = 1'b1;
      n0 = nstarts;
      cyc(20);
      chk("post_rst_no_start", 32'(nstarts - n0), 32'd0);
      chk("post_rst_empty", 32'(empty), 32'd1);
      wr(8'hA5, 1'b1);
      wait_quiet(100);
      chk("post_rst_new_start", 32'(nstarts - n0), 32'd1);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
